// File: rtl/lag_bcd_encoder_pkg.sv
// -----------------------------------------------------------------------------
// lag_bcd_encoder_pkg
// Shared types and constants for the lag statistics BCD encoder.
//   - LAG_BIN_W      : default width of each binary lag input
//   - MAX_BCDCOUNT   : 5-digit "blank" sentinel understood by the text renderer
//   - MAX_BLANK      : value the renderer treats as a blank max field
//   - BLANK_BUS      : bcdcount with every field blank (reset value)
//   - lag_fsm_state_t: control FSM states
//   - bcd_adjust()   : double-dabble "add 3 to every nibble >= 5" step
// -----------------------------------------------------------------------------
package lag_bcd_encoder_pkg;

    localparam int          LAG_BIN_W    = 17;
    localparam logic [19:0] MAX_BCDCOUNT = 20'h99999;
    localparam logic [19:0] MAX_BLANK    = 20'h00000;

    // Field order on the bus is {avg, max, min, lag}.
    localparam logic [79:0] BLANK_BUS = {MAX_BCDCOUNT, MAX_BLANK, MAX_BCDCOUNT, MAX_BCDCOUNT};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE,
        PEND
    } lag_fsm_state_t;

    function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
        logic [19:0] res;
        res = bcd;
        for (int d = 0; d < 5; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                res[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lag_bcd_encoder_bin2bcd_serial.sv
// -----------------------------------------------------------------------------
// lag_bcd_encoder_bin2bcd_serial
// Serial double-dabble converter: one shift per step, BIN_W steps per value.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   load         : capture bin, clear the BCD accumulator, arm the step counter
//   step         : perform one adjust-and-shift step
//   bin          : binary value to convert (must already be <= 99999)
//   done         : high during the final step of a conversion
//   bcd          : 5-digit packed BCD result, valid once the last step is taken
// -----------------------------------------------------------------------------
module lag_bcd_encoder_bin2bcd_serial
    import lag_bcd_encoder_pkg::*;
#(
    parameter int BIN_W = LAG_BIN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [19:0]      bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_sr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_sr <= '0;
            cnt    <= '0;
            bcd    <= '0;
        end else if (load) begin
            bin_sr <= bin;
            cnt    <= CNT_W'(BIN_W);
            bcd    <= '0;
        end else if (step && (cnt != '0)) begin
            // Adjusted BCD shifted left with the next binary MSB entering at bit 0;
            // the value is clamped upstream so nothing is lost off the top.
            bcd    <= 20'({bcd_adjust(bcd), bin_sr[BIN_W-1]});
            bin_sr <= bin_sr << 1;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    assign done = step && (cnt == CNT_W'(1));

endmodule

// File: rtl/lag_bcd_encoder.sv
// -----------------------------------------------------------------------------
// lag_bcd_encoder
// Converts four binary lag statistics to packed BCD with one shared serial
// converter and publishes all four fields together on a frame-sync strobe.
// Ports:
//   clock, reset  : pixel clock and asynchronous active-high reset
//   start         : 1-cycle pulse; samples inputs and starts a conversion (IDLE only)
//   lag_bin       : current lag        min_bin : minimum lag
//   max_bin       : maximum lag        avg_bin : average lag
//   valid_mask    : [0]=lag [1]=min [2]=max [3]=avg, 0 = value not available
//   frame_sync    : 1-cycle pulse per frame; publishes a pending result
//   busy          : high from the cycle after an accepted start until the
//                   last field is written to the shadow register
//   bcdcount      : {avg, max, min, lag}, 5 BCD digits each
// -----------------------------------------------------------------------------
module lag_bcd_encoder
    import lag_bcd_encoder_pkg::*;
#(
    parameter int BIN_W     = LAG_BIN_W,
    parameter int CLAMP_VAL = 99998
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] lag_bin,
    input  logic [BIN_W-1:0] min_bin,
    input  logic [BIN_W-1:0] max_bin,
    input  logic [BIN_W-1:0] avg_bin,
    input  logic [3:0]       valid_mask,
    input  logic             frame_sync,
    output logic             busy,
    output logic [79:0]      bcdcount
);

    lag_fsm_state_t   state;
    logic [1:0]       idx;
    logic             pending;
    logic [3:0][19:0] shadow;

    logic [BIN_W-1:0] cap_bin [4];
    logic [3:0]       cap_mask;

    logic             accept;
    logic             cur_valid;
    logic [BIN_W-1:0] cur_bin;
    logic [BIN_W-1:0] load_val;
    logic [19:0]      store_val;
    logic             eng_load;
    logic             eng_step;
    logic             eng_done;
    logic [19:0]      eng_bcd;

    assign accept = start && (state == IDLE);

    // NOTE: pure data capture registers carry no reset; they are only read
    // after an accepted start has loaded them, so resetting them buys nothing.
    always_ff @(posedge clock) begin
        if (accept) begin
            cap_bin[0] <= lag_bin;
            cap_bin[1] <= min_bin;
            cap_bin[2] <= max_bin;
            cap_bin[3] <= avg_bin;
            cap_mask   <= valid_mask;
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and infers a latch.
    always_comb begin
        cur_valid = cap_mask[idx];
        cur_bin   = cap_bin[idx];
        load_val  = cur_bin;
        if (cur_bin > BIN_W'(CLAMP_VAL)) begin
            load_val = BIN_W'(CLAMP_VAL);
        end
        store_val = eng_bcd;
        if (!cur_valid) begin
            // The renderer blanks max on zero, every other field on the sentinel.
            store_val = (idx == 2'd2) ? MAX_BLANK : MAX_BCDCOUNT;
        end
    end

    assign eng_load = (state == LOAD) && cur_valid;
    assign eng_step = (state == SHIFT);

    lag_bcd_encoder_bin2bcd_serial #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .load  (eng_load),
        .step  (eng_step),
        .bin   (load_val),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of all the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 2'd0;
            busy     <= 1'b0;
            pending  <= 1'b0;
            shadow   <= '0;
            bcdcount <= BLANK_BUS;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                        // The shadow is about to be rewritten field by field;
                        // publishing it before the new result is complete
                        // would tear the bus.
                        pending <= 1'b0;
                    end
                end
                LOAD: begin
                    state <= cur_valid ? SHIFT : STORE;
                end
                SHIFT: begin
                    if (eng_done) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    shadow[idx] <= store_val;
                    idx         <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= PEND;
                        busy  <= 1'b0;
                    end else begin
                        state <= LOAD;
                    end
                end
                PEND: begin
                    pending <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // pending is never set while in PEND, so this cannot collide with
            // the PEND branch above.
            if (frame_sync && pending) begin
                bcdcount <= shadow;
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lag_bcd_encoder.sv
// -----------------------------------------------------------------------------
// tb_lag_bcd_encoder
// Self-checking bench for lag_bcd_encoder. Expected buses are computed from a
// decimal model, queued when a conversion is started and compared when the
// DUT publishes on frame_sync.
// -----------------------------------------------------------------------------
module tb_lag_bcd_encoder;

    localparam int          BIN_W = 17;
    localparam logic [79:0] BLANK = {20'h99999, 20'h00000, 20'h99999, 20'h99999};

    logic             clock;
    logic             reset;
    logic             start;
    logic [BIN_W-1:0] lag_bin;
    logic [BIN_W-1:0] min_bin;
    logic [BIN_W-1:0] max_bin;
    logic [BIN_W-1:0] avg_bin;
    logic [3:0]       valid_mask;
    logic             frame_sync;
    logic             busy;
    logic [79:0]      bcdcount;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [79:0] exp_q [$];
    logic [79:0] cur_bus;

    lag_bcd_encoder dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .lag_bin    (lag_bin),
        .min_bin    (min_bin),
        .max_bin    (max_bin),
        .avg_bin    (avg_bin),
        .valid_mask (valid_mask),
        .frame_sync (frame_sync),
        .busy       (busy),
        .bcdcount   (bcdcount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp_val);
        tests_run++;
        if (got !== exp_val) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp_val);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [19:0] exp_field(input int v, input bit valid, input bit is_max);
        int t;
        if (!valid) return is_max ? 20'h00000 : 20'h99999;
        t = (v > 99998) ? 99998 : v;
        return to_bcd(t);
    endfunction

    task automatic scramble_inputs();
        lag_bin    = BIN_W'($urandom);
        min_bin    = BIN_W'($urandom);
        max_bin    = BIN_W'($urandom);
        avg_bin    = BIN_W'($urandom);
        valid_mask = 4'($urandom);
    endtask

    // Starts a conversion, measures busy, optionally pulses frame_sync or a
    // second start while busy, then publishes and compares against the model.
    task automatic run_conv(input int l, input int mn, input int mx, input int av,
                            input logic [3:0] mask, input int exp_busy,
                            input int fs_at, input int restart_at);
        logic [79:0] exp_bus;
        int          n;
        exp_q.push_back({exp_field(av, mask[3], 1'b0), exp_field(mx, mask[2], 1'b1),
                         exp_field(mn, mask[1], 1'b0), exp_field(l, mask[0], 1'b0)});
        lag_bin    = BIN_W'(l);
        min_bin    = BIN_W'(mn);
        max_bin    = BIN_W'(mx);
        avg_bin    = BIN_W'(av);
        valid_mask = mask;
        start      = 1'b1;
        tick();
        start = 1'b0;
        scramble_inputs();
        check("busy_after_start", 80'(busy), 80'(1));
        n = 0;
        while (busy && n < 200) begin
            if (n == fs_at) frame_sync = 1'b1;
            if (n == restart_at) begin
                start = 1'b1;
                scramble_inputs();
            end
            tick();
            frame_sync = 1'b0;
            start      = 1'b0;
            n++;
        end
        check("busy_cycles", 80'(n), 80'(exp_busy));
        if (fs_at >= 0) check("hold_while_busy", bcdcount, cur_bus);
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        exp_bus = exp_q.pop_front();
        check("bcdcount", bcdcount, exp_bus);
        check("idle_after_commit", 80'(busy), 80'(0));
        cur_bus = exp_bus;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        frame_sync = 1'b0;
        lag_bin    = '0;
        min_bin    = '0;
        max_bin    = '0;
        avg_bin    = '0;
        valid_mask = '0;
        cur_bus    = BLANK;
        #1;
        check("reset_busy", 80'(busy), 80'(0));
        check("reset_bcdcount", bcdcount, BLANK);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Case 1: frame_sync with nothing pending leaves the blank bus.
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("blank_after_fsync", bcdcount, BLANK);

        // Case 2: all valid.
        run_conv(12345, 100, 65535, 7, 4'hF, 76, -1, -1);

        // Case 3: only lag valid and above the clamp.
        run_conv(120000, 555, 777, 999, 4'b0001, 25, -1, -1);

        // Clamp boundaries and invalid max with the others valid.
        run_conv(99998, 99999, 0, 131071, 4'b1011, 59, -1, -1);

        // Case 4: frame_sync mid-conversion, then coincident with the avg STORE.
        run_conv(11111, 22222, 33333, 44444, 4'hF, 76, 30, -1);
        run_conv(54321, 1, 99998, 9, 4'hF, 76, 75, -1);

        // Case 5: second start 10 cycles in is ignored.
        run_conv(31415, 27182, 16180, 14142, 4'hF, 76, -1, 10);

        // Case 6: reset at cycle 40 of a conversion.
        lag_bin    = BIN_W'(88888);
        min_bin    = BIN_W'(12);
        max_bin    = BIN_W'(34);
        avg_bin    = BIN_W'(56);
        valid_mask = 4'hF;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        check("busy_mid_conv", 80'(busy), 80'(1));
        reset = 1'b1;
        #1;
        check("abort_busy", 80'(busy), 80'(0));
        check("abort_bcdcount", bcdcount, BLANK);
        tick();
        reset = 1'b0;
        cur_bus = BLANK;
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        check("no_commit_after_abort", bcdcount, BLANK);
        run_conv(42, 0, 99, 1000, 4'hF, 76, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
